// File: rtl/eth_frame_bridge_if.sv
// Byte-stream bundle between rmii_rx, eth_frame_bridge and the UART TX FIFO.
// slave = bridge view (consumes in_*, drives out_wren/out_data); master = source/sink side.
interface eth_frame_bridge_if;
  logic       in_frame;
  logic       in_dv;
  logic [7:0] in_data;
  logic       out_full;
  logic       out_wren;
  logic [7:0] out_data;

  modport master (
    output in_frame, in_dv, in_data, out_full,
    input  out_wren, out_data
  );

  modport slave (
    input  in_frame, in_dv, in_data, out_full,
    output out_wren, out_data
  );
endinterface

// File: rtl/eth_frame_bridge.sv
// Store-and-forward RMII frame -> SYNC/LEN_HI/LEN_LO/payload records; ETH_BRIDGE_CHECKSUM_EN appends an XOR byte.
// First SYNC strobe 2 cycles after commit; out_full stalls the record byte-for-byte, registered out_data holds.
module eth_frame_bridge #(
  parameter int         BUF_DEPTH = 2048,
  parameter int         LEN_DEPTH = 8,
  parameter int         MIN_FRAME = 14,
  parameter int         MAX_FRAME = 1536,
  parameter int         CNT_W     = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              eth_clk,
  input  logic              sys_rst_n,
  eth_frame_bridge_if.slave bus,
  output logic [CNT_W-1:0]  frames_dropped,
  output logic              busy
);
  localparam int AW  = $clog2(BUF_DEPTH);
  localparam int PW  = AW + 1;
  localparam int LAW = $clog2(LEN_DEPTH);
  localparam int LPW = LAW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LEN_HI,
    S_LEN_LO,
`ifdef ETH_BRIDGE_CHECKSUM_EN
    S_DATA,
    S_CSUM
`else
    S_DATA
`endif
  } state_t;

  logic [7:0]     mem     [BUF_DEPTH];
  logic [15:0]    len_mem [LEN_DEPTH];

  logic [PW-1:0]  wr_ptr, frame_start, rd_ptr, fp, fp_n, used;
  logic [LPW-1:0] lw_ptr, lr_ptr;
  logic [15:0]    wlen, rem, len_head;
  logic [7:0]     rd_q, out_q;
  logic           in_frame_q, bad;
  logic           frame_end, buf_full, len_full, len_empty, len_ok;
  logic           accept, do_write, commit, send, fp_inc, byte_ready;
  state_t         state;
`ifdef ETH_BRIDGE_CHECKSUM_EN
  logic [7:0]     csum;
`endif

  assign frame_end = in_frame_q & ~bus.in_frame;
  assign used      = wr_ptr - rd_ptr;
  assign buf_full  = (used == PW'(BUF_DEPTH));
  assign len_full  = ((lw_ptr - lr_ptr) == LPW'(LEN_DEPTH));
  assign len_empty = (lw_ptr == lr_ptr);
  assign len_head  = len_mem[lr_ptr[LAW-1:0]];
  assign accept    = bus.in_frame & bus.in_dv & ~bad;
  assign do_write  = accept & ~buf_full & (wlen != 16'(MAX_FRAME));
  assign len_ok    = (wlen >= 16'(MIN_FRAME)) && (wlen <= 16'(MAX_FRAME));
  assign commit    = frame_end & ~bad & len_ok & ~len_full;

  assign send          = byte_ready & ~bus.out_full;
  assign bus.out_wren  = send;
  assign bus.out_data  = out_q;

  // fp is the address of the next payload byte to load into out_q; rd_q always mirrors mem[fp].
  assign fp_inc = send & ((state == S_LEN_LO) | ((state == S_DATA) & (rem != 16'd1)));
  assign fp_n   = fp + PW'(fp_inc);

  always_ff @(posedge eth_clk) begin
    if (do_write)
      mem[wr_ptr[AW-1:0]] <= bus.in_data;
    if (commit)
      len_mem[lw_ptr[LAW-1:0]] <= wlen;
    rd_q <= mem[fp_n[AW-1:0]];
  end

  always_ff @(posedge eth_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      in_frame_q     <= 1'b0;
      bad            <= 1'b0;
      wlen           <= '0;
      wr_ptr         <= '0;
      frame_start    <= '0;
      lw_ptr         <= '0;
      frames_dropped <= '0;
    end else begin
      in_frame_q <= bus.in_frame;
      if (frame_end) begin
        wlen <= '0;
        bad  <= 1'b0;
        if (commit) begin
          frame_start <= wr_ptr;
          lw_ptr      <= lw_ptr + LPW'(1);
        end else begin
          wr_ptr <= frame_start;
          if (frames_dropped != {CNT_W{1'b1}})
            frames_dropped <= frames_dropped + CNT_W'(1);
        end
      end else if (accept) begin
        if (do_write) begin
          wr_ptr <= wr_ptr + PW'(1);
          wlen   <= wlen + 16'd1;
        end else begin
          bad <= 1'b1;
        end
      end
    end
  end

  // The length entry stays in the FIFO until its SYNC byte is accepted, so a
  // stalled record still occupies a slot.
  always_ff @(posedge eth_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      byte_ready <= 1'b0;
      out_q      <= '0;
      busy       <= 1'b0;
      rem        <= '0;
      rd_ptr     <= '0;
      fp         <= '0;
      lr_ptr     <= '0;
`ifdef ETH_BRIDGE_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      fp <= fp_n;
      case (state)
        S_IDLE: begin
          if (!len_empty) begin
            state      <= S_SYNC;
            rem        <= len_head;
            out_q      <= SYNC_BYTE;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_SYNC: begin
`ifdef ETH_BRIDGE_CHECKSUM_EN
          csum <= '0;
`endif
          if (send) begin
            lr_ptr <= lr_ptr + LPW'(1);
            state  <= S_LEN_HI;
            out_q  <= rem[15:8];
          end
        end
        S_LEN_HI: begin
          if (send) begin
            state <= S_LEN_LO;
            out_q <= rem[7:0];
          end
        end
        S_LEN_LO: begin
          if (send) begin
            state <= S_DATA;
            out_q <= rd_q;
          end
        end
        S_DATA: begin
          if (send) begin
            rd_ptr <= rd_ptr + PW'(1);
            rem    <= rem - 16'd1;
`ifdef ETH_BRIDGE_CHECKSUM_EN
            csum   <= csum ^ out_q;
`endif
            if (rem == 16'd1) begin
`ifdef ETH_BRIDGE_CHECKSUM_EN
              state <= S_CSUM;
              out_q <= csum ^ out_q;
`else
              state      <= S_IDLE;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
`endif
            end else begin
              out_q <= rd_q;
            end
          end
        end
`ifdef ETH_BRIDGE_CHECKSUM_EN
        S_CSUM: begin
          if (send) begin
            state      <= S_IDLE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
          end
        end
`endif
        default: begin
          state      <= S_IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_eth_frame_bridge.sv
// Scoreboard bench for eth_frame_bridge: frames in, expected record bytes queued, compared per out_wren.
module tb_eth_frame_bridge;
`ifdef ETH_BRIDGE_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        eth_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [15:0] frames_dropped;
  logic        busy;

  eth_frame_bridge_if bus();

  eth_frame_bridge dut (
    .eth_clk        (eth_clk),
    .sys_rst_n      (sys_rst_n),
    .bus            (bus),
    .frames_dropped (frames_dropped),
    .busy           (busy)
  );

  always #5 eth_clk = ~eth_clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         wren_cnt = 0;
  int         first_wren_cyc = -1;
  int         end_cyc = 0;
  bit         rand_full = 1'b0;
  logic [7:0] exp_q[$];

  task automatic sb_sample();
    logic [7:0] e;
    if (sys_rst_n === 1'b1 && bus.out_wren === 1'b1) begin
      if (wren_cnt == 0) first_wren_cyc = cyc;
      wren_cnt++;
      checks++;
      if (bus.out_full !== 1'b0) begin
        errors++;
        $display("FAIL wren_while_full: out_wren=1 with out_full=%b at cycle %0d", bus.out_full, cyc);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got %h, required no output", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          errors++;
          $display("FAIL out_byte: got %h, required %h (byte %0d)", bus.out_data, e, wren_cnt);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge eth_clk);
    sb_sample();
    @(posedge eth_clk);
    cyc++;
    #1;
    if (rand_full) bus.out_full = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [7:0] pat_byte(input int pat, input int i);
    logic [7:0] b;
    case (pat)
      0:       b = 8'(i);
      1:       b = 8'(1 << (i % 8));
      default: b = 8'($urandom_range(0, 255));
    endcase
    return b;
  endfunction

  task automatic send_frame(input int n, input int pat, input bit ok);
    logic [15:0] ln;
    logic [7:0]  b;
    logic [7:0]  x;
    ln = 16'(n);
    x  = 8'h00;
    if (ok) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(ln[15:8]);
      exp_q.push_back(ln[7:0]);
    end
    bus.in_frame = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      b = pat_byte(pat, i);
      x = x ^ b;
      if (ok) exp_q.push_back(b);
      bus.in_dv   = 1'b1;
      bus.in_data = b;
      tick();
      bus.in_dv = 1'b0;
      tick();
    end
`ifdef ETH_BRIDGE_CHECKSUM_EN
    if (ok) exp_q.push_back(x);
`endif
    bus.in_frame = 1'b0;
    end_cyc = cyc;
    repeat (12) tick();
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes pending busy=%b, required 0 pending busy=0", name, exp_q.size(), busy);
    end
  endtask

  task automatic do_reset();
    rand_full    = 1'b0;
    bus.in_frame = 1'b0;
    bus.in_dv    = 1'b0;
    bus.in_data  = 8'h00;
    bus.out_full = 1'b0;
    sys_rst_n    = 1'b0;
    repeat (2) tick();
    exp_q.delete();
    wren_cnt       = 0;
    first_wren_cyc = -1;
    sys_rst_n      = 1'b1;
    tick();
  endtask

  task automatic check_dropped(input int exp, input string name);
    checks++;
    if (frames_dropped !== 16'(exp)) begin
      errors++;
      $display("FAIL %s_dropped: got %0d, required %0d", name, frames_dropped, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.out_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b, required 0", bus.out_wren); end
    checks++;
    if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, required 00", bus.out_data); end
    checks++;
    if (frames_dropped !== 16'd0) begin errors++; $display("FAIL reset_dropped: got %0d, required 0", frames_dropped); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
  endtask

  task automatic test_single();
    do_reset();
    send_frame(64, 0, 1'b1);
    wait_drain(500, "single");
    check_dropped(0, "single");
    checks++;
    if (wren_cnt != 67 + EXTRA) begin
      errors++;
      $display("FAIL single_count: got %0d bytes, required %0d", wren_cnt, 67 + EXTRA);
    end
    checks++;
    if (first_wren_cyc < 0 || first_wren_cyc - end_cyc < 2) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles, required >= 2", first_wren_cyc - end_cyc);
    end
  endtask

  task automatic test_runt();
    do_reset();
    bus.in_dv   = 1'b1;
    bus.in_data = 8'hEE;
    tick();
    bus.in_dv = 1'b0;
    tick();
    send_frame(10, 0, 1'b0);
    send_frame(60, 2, 1'b1);
    wait_drain(500, "runt");
    check_dropped(1, "runt");
  endtask

  task automatic test_oversize();
    do_reset();
    send_frame(1600, 0, 1'b0);
    check_dropped(1, "oversize");
    checks++;
    if (wren_cnt != 0) begin errors++; $display("FAIL oversize_output: got %0d bytes, required 0", wren_cnt); end
    send_frame(1536, 2, 1'b1);
    wait_drain(3000, "maxlen");
    check_dropped(1, "maxlen");
  endtask

  task automatic test_len_fifo_full();
    do_reset();
    bus.out_full = 1'b1;
    for (int f = 0; f < 9; f++) send_frame(100, 2, f < 8);
    check_dropped(1, "lenfifo");
    checks++;
    if (wren_cnt != 0) begin errors++; $display("FAIL lenfifo_stall: got %0d bytes while full, required 0", wren_cnt); end
    bus.out_full = 1'b0;
    wait_drain(5000, "lenfifo");
    checks++;
    if (wren_cnt != 8 * (103 + EXTRA)) begin
      errors++;
      $display("FAIL lenfifo_count: got %0d bytes, required %0d", wren_cnt, 8 * (103 + EXTRA));
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.out_full = 1'b1;
    send_frame(1000, 2, 1'b1);
    send_frame(1000, 2, 1'b1);
    send_frame(100, 2, 1'b0);
    check_dropped(1, "overflow");
    bus.out_full = 1'b0;
    wait_drain(5000, "overflow");
    send_frame(100, 2, 1'b1);
    wait_drain(500, "wrap");
    check_dropped(1, "wrap");
  endtask

  task automatic test_random_backpressure();
    do_reset();
    rand_full = 1'b1;
    send_frame(14, 1, 1'b1);
    send_frame(40, 2, 1'b1);
    wait_drain(2000, "randbp");
    rand_full    = 1'b0;
    bus.out_full = 1'b0;
  endtask

  task automatic test_reset_mid_data();
    int n;
    do_reset();
    send_frame(200, 2, 1'b1);
    n = 0;
    while (wren_cnt < 20 && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (wren_cnt < 20) begin errors++; $display("FAIL midreset_start: got %0d bytes, required >= 20", wren_cnt); end
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_wren !== 1'b0) begin errors++; $display("FAIL midreset_wren: got %b, required 0", bus.out_wren); end
    repeat (2) tick();
    exp_q.delete();
    wren_cnt  = 0;
    sys_rst_n = 1'b1;
    tick();
    send_frame(30, 2, 1'b1);
    wait_drain(500, "midreset");
    check_dropped(0, "midreset");
    checks++;
    if (wren_cnt != 33 + EXTRA) begin
      errors++;
      $display("FAIL midreset_count: got %0d bytes, required %0d", wren_cnt, 33 + EXTRA);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_runt();
    test_oversize();
    test_len_fifo_full();
    test_overflow();
    test_random_backpressure();
    test_reset_mid_data();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
